// File: rtl/phase_pkg.sv
// Shared types and helpers for the intersection phase scheduler.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package phase_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2,
    ALLRED = 2'd3
  } state_t;

  // Direction indices, matching bit positions of req/grant/lamp buses.
  localparam int DIR_N = 0;
  localparam int DIR_S = 1;
  localparam int DIR_E = 2;
  localparam int DIR_W = 3;

  typedef struct packed {
    logic [3:0] green;
    logic [3:0] yellow;
    logic [3:0] red;
  } lamp_t;

  // Maps a phase plus the owning direction to per-direction lamps.
  // Every direction ends up with exactly one lamp lit.
  function automatic lamp_t lamp_triple(input state_t s, input logic [3:0] g);
    lamp_t l;
    l.green  = 4'b0000;
    l.yellow = 4'b0000;
    l.red    = 4'b1111;
    case (s)
      GREEN: begin
        l.green = g;
        l.red   = ~g;
      end
      YELLOW: begin
        l.yellow = g;
        l.red    = ~g;
      end
      default: ;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/phase_scheduler_if.sv
// Signal bundle between tick source/request inputs and the lamp drivers.
// Latency: n/a (wires only).
// Backpressure: none; tick is a plain enable, req are level requests.
// Signals: tick, req[3:0] in; lamp_green/yellow/red[3:0], grant[3:0],
// remaining[CNT_W-1:0], busy out. With PHASE_PREEMPT_EN defined the
// bundle also carries preempt and preempt_dir[1:0].
interface phase_scheduler_if #(
  parameter int CNT_W = 8
);
  logic             tick;
  logic [3:0]       req;
  logic [3:0]       lamp_green;
  logic [3:0]       lamp_yellow;
  logic [3:0]       lamp_red;
  logic [3:0]       grant;
  logic [CNT_W-1:0] remaining;
  logic             busy;
`ifdef PHASE_PREEMPT_EN
  logic             preempt;
  logic [1:0]       preempt_dir;

  modport master (output tick, req, preempt, preempt_dir,
                  input  lamp_green, lamp_yellow, lamp_red, grant, remaining, busy);
  modport slave  (input  tick, req, preempt, preempt_dir,
                  output lamp_green, lamp_yellow, lamp_red, grant, remaining, busy);
`else
  modport master (output tick, req,
                  input  lamp_green, lamp_yellow, lamp_red, grant, remaining, busy);
  modport slave  (input  tick, req,
                  output lamp_green, lamp_yellow, lamp_red, grant, remaining, busy);
`endif
endinterface

// File: rtl/phase_scheduler_rr_arbiter4.sv
// 4-way round-robin pick: first eligible bit at or above ptr, wrapping 3->0.
// Latency: combinational.
// Backpressure: none; the caller decides whether to act on the pick.
// Ports: eligible_i[3:0], ptr_i[1:0] in; win_o[3:0] one-hot, idx_o[1:0], vld_o out.
module rr_arbiter4 (
  input  logic [3:0] eligible_i,
  input  logic [1:0] ptr_i,
  output logic [3:0] win_o,
  output logic [1:0] idx_o,
  output logic       vld_o
);

  logic [1:0] k;

  always_comb begin
    win_o = 4'b0000;
    idx_o = ptr_i;
    vld_o = 1'b0;
    k     = 2'd0;
    for (int i = 0; i < 4; i++) begin
      k = ptr_i + 2'(i);  // 2-bit add wraps W back to N
      if (!vld_o && eligible_i[k]) begin
        vld_o    = 1'b1;
        idx_o    = k;
        win_o[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/phase_scheduler.sv
// Demand-driven GREEN/YELLOW/ALLRED sequencer for a 4-approach intersection.
// Latency: IDLE->GREEN one clk after a request; phase timing counts ticks only.
// Backpressure: none; requests are latched in pending until served.
// Ports: clk, rst_n (async active-low); bus (slave modport) carries tick, req,
// lamps, grant, remaining, busy. All outputs are registered.
// Optional: PHASE_PREEMPT_EN adds preempt/preempt_dir emergency override.
module phase_scheduler
  import phase_pkg::*;
#(
  parameter int CNT_W        = 8,
  parameter int GREEN_TICKS  = 20,
  parameter int YELLOW_TICKS = 4,
  parameter int ALLRED_TICKS = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  phase_scheduler_if.slave  bus
);

  localparam logic [CNT_W-1:0] G_LOAD = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] Y_LOAD = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] A_LOAD = CNT_W'(ALLRED_TICKS - 1);

  state_t           state_q, state_d;
  logic [3:0]       grant_q, grant_d;
  logic [3:0]       pending_q, pending_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  lamp_t            lamp_q, lamp_d;
  logic             busy_q, busy_d;

  logic [3:0] eligible;
  logic [3:0] arb_win;
  logic [1:0] arb_idx;
  logic       arb_vld;
  logic       enter_green;

`ifdef PHASE_PREEMPT_EN
  logic [3:0] pre_oh;
  assign pre_oh = 4'b0001 << bus.preempt_dir;
`endif

  assign eligible = pending_q | bus.req;

  rr_arbiter4 u_arb (
    .eligible_i (eligible),
    .ptr_i      (ptr_q),
    .win_o      (arb_win),
    .idx_o      (arb_idx),
    .vld_o      (arb_vld)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= 4'b0000;
      pending_q <= 4'b0000;
      ptr_q     <= 2'(DIR_N);
      cnt_q     <= '0;
      lamp_q    <= '{green: 4'b0000, yellow: 4'b0000, red: 4'b1111};
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      pending_q <= pending_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      lamp_q    <= lamp_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        // No tick needed to leave IDLE; a coincident tick is not counted.
        if (arb_vld) begin
          state_d = GREEN;
          grant_d = arb_win;
          cnt_d   = G_LOAD;
          ptr_d   = arb_idx + 2'd1;
        end
      end
      GREEN: begin
`ifdef PHASE_PREEMPT_EN
        if (bus.preempt) begin
          // Preempted direction already green: hold with counter frozen.
          if (grant_q != pre_oh && bus.tick) begin
            state_d = YELLOW;
            cnt_d   = Y_LOAD;
          end
        end else
`endif
        if (bus.tick) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else if ((eligible & ~grant_q) != 4'b0000) begin
            state_d = YELLOW;
            cnt_d   = Y_LOAD;
          end
          // else rest on green at zero and re-evaluate next tick
        end
      end
      YELLOW: begin
        if (bus.tick) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            state_d = ALLRED;
            grant_d = 4'b0000;
            cnt_d   = A_LOAD;
          end
        end
      end
      ALLRED: begin
        if (bus.tick) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end
`ifdef PHASE_PREEMPT_EN
          else if (bus.preempt) begin
            // Override grant leaves the round-robin pointer untouched.
            state_d = GREEN;
            grant_d = pre_oh;
            cnt_d   = G_LOAD;
          end
`endif
          else if (arb_vld) begin
            state_d = GREEN;
            grant_d = arb_win;
            cnt_d   = G_LOAD;
            ptr_d   = arb_idx + 2'd1;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 4'b0000;
        cnt_d   = '0;
      end
    endcase

    // Granted bit is cleared on GREEN entry; the clear beats a same-clk req.
    enter_green = (state_d == GREEN) && (state_q != GREEN);
    pending_d   = (pending_q | bus.req) & ~(enter_green ? grant_d : 4'b0000);
  end

  // Output logic: registered from next state so outputs align with state_q.
  always_comb begin
    lamp_d = lamp_triple(state_d, grant_d);
    busy_d = (state_d != IDLE);
  end

  assign bus.lamp_green  = lamp_q.green;
  assign bus.lamp_yellow = lamp_q.yellow;
  assign bus.lamp_red    = lamp_q.red;
  assign bus.grant       = grant_q;
  assign bus.remaining   = cnt_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_phase_scheduler.sv
// Directed bench for phase_scheduler with hand-computed expected vectors.
// Each observed vector is {green, yellow, red, grant, remaining, busy}.
module tb_phase_scheduler;
  import phase_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  phase_scheduler_if #(.CNT_W(8)) bus ();

  phase_scheduler #(
    .CNT_W(8), .GREEN_TICKS(20), .YELLOW_TICKS(4), .ALLRED_TICKS(2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [28:0] obs;
  assign obs = {bus.lamp_green, bus.lamp_yellow, bus.lamp_red, bus.grant, bus.remaining, bus.busy};

  localparam logic [28:0] IDLE_V = {4'b0000, 4'b0000, 4'b1111, 4'b0000, 8'd0, 1'b0};
  localparam logic [3:0] N_OH = 4'b0001;
  localparam logic [3:0] S_OH = 4'b0010;
  localparam logic [3:0] E_OH = 4'b0100;
  localparam logic [3:0] W_OH = 4'b1000;

  function automatic logic [28:0] vgreen(input logic [3:0] d, input logic [7:0] rem);
    return {d, 4'b0000, ~d, d, rem, 1'b1};
  endfunction
  function automatic logic [28:0] vyellow(input logic [3:0] d, input logic [7:0] rem);
    return {4'b0000, d, ~d, d, rem, 1'b1};
  endfunction
  function automatic logic [28:0] vallred(input logic [7:0] rem);
    return {4'b0000, 4'b0000, 4'b1111, 4'b0000, rem, 1'b1};
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    bus.tick = 1'b0;
    bus.req  = 4'b0000;
    rst_n    = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (obs !== IDLE_V) $display("FAIL reset_vals: got %b want %b", obs, IDLE_V); else n_pass++;
    @(negedge clk);
    rst_n    = 1'b1;
    bus.tick = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step(1);
      n_total++; if (obs !== IDLE_V) $display("FAIL idle_ticks[%0d]: got %b want %b", i, obs, IDLE_V); else n_pass++;
    end
  endtask

  task automatic test_single_demand();
    bus.req = E_OH;
    step(1);
    bus.req = 4'b0000;
    n_total++; if (obs !== vgreen(E_OH, 8'd19)) $display("FAIL e_green_entry: got %b want %b", obs, vgreen(E_OH, 8'd19)); else n_pass++;
    for (int r = 18; r >= 0; r--) begin
      step(1);
      n_total++; if (obs !== vgreen(E_OH, 8'(r))) $display("FAIL e_green_cnt[%0d]: got %b want %b", r, obs, vgreen(E_OH, 8'(r))); else n_pass++;
    end
    for (int i = 0; i < 10; i++) begin
      step(1);
      n_total++; if (obs !== vgreen(E_OH, 8'd0)) $display("FAIL e_rest[%0d]: got %b want %b", i, obs, vgreen(E_OH, 8'd0)); else n_pass++;
    end
    bus.req = N_OH;
    step(1);
    bus.req = 4'b0000;
    for (int r = 3; r >= 0; r--) begin
      if (r != 3) step(1);
      n_total++; if (obs !== vyellow(E_OH, 8'(r))) $display("FAIL e_yellow[%0d]: got %b want %b", r, obs, vyellow(E_OH, 8'(r))); else n_pass++;
    end
    for (int r = 1; r >= 0; r--) begin
      step(1);
      n_total++; if (obs !== vallred(8'(r))) $display("FAIL e_allred[%0d]: got %b want %b", r, obs, vallred(8'(r))); else n_pass++;
    end
    step(1);
    n_total++; if (obs !== vgreen(N_OH, 8'd19)) $display("FAIL n_green_entry: got %b want %b", obs, vgreen(N_OH, 8'd19)); else n_pass++;
    // E must not come back: N rests on green once its count expires.
    step(19);
    for (int i = 0; i < 10; i++) begin
      step(1);
      n_total++; if (obs !== vgreen(N_OH, 8'd0)) $display("FAIL n_rest_no_e[%0d]: got %b want %b", i, obs, vgreen(N_OH, 8'd0)); else n_pass++;
    end
  endtask

  task automatic test_round_robin();
    int          seq [5];
    logic [3:0]  cur, nxt;
    int          viol;
    seq  = '{DIR_N, DIR_S, DIR_E, DIR_W, DIR_N};
    viol = 0;
    @(negedge clk);
    rst_n   = 1'b0;
    bus.req = 4'b1111;
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
    n_total++; if (obs !== vgreen(N_OH, 8'd19)) $display("FAIL rr_first: got %b want %b", obs, vgreen(N_OH, 8'd19)); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      cur = 4'b0001 << seq[k];
      nxt = 4'b0001 << seq[k+1];
      for (int r = 18; r >= 0; r--) begin
        step(1);
        if ($countones(~bus.lamp_red) > 1) viol++;
        n_total++; if (obs !== vgreen(cur, 8'(r))) $display("FAIL rr_green[%0d][%0d]: got %b want %b", k, r, obs, vgreen(cur, 8'(r))); else n_pass++;
      end
      for (int r = 3; r >= 0; r--) begin
        step(1);
        if ($countones(~bus.lamp_red) > 1) viol++;
        n_total++; if (obs !== vyellow(cur, 8'(r))) $display("FAIL rr_yellow[%0d][%0d]: got %b want %b", k, r, obs, vyellow(cur, 8'(r))); else n_pass++;
      end
      for (int r = 1; r >= 0; r--) begin
        step(1);
        n_total++; if (obs !== vallred(8'(r))) $display("FAIL rr_allred[%0d][%0d]: got %b want %b", k, r, obs, vallred(8'(r))); else n_pass++;
      end
      step(1);
      n_total++; if (obs !== vgreen(nxt, 8'd19)) $display("FAIL rr_next[%0d]: got %b want %b", k, obs, vgreen(nxt, 8'd19)); else n_pass++;
    end
    n_total++; if (viol !== 0) $display("FAIL rr_multi_nonred: got %0d want 0", viol); else n_pass++;
    bus.req = 4'b0000;
  endtask

  task automatic test_same_clk_clear();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(2);
    bus.req = S_OH | W_OH;
    step(1);
    bus.req = 4'b0000;
    n_total++; if (obs !== vgreen(S_OH, 8'd19)) $display("FAIL clr_s_entry: got %b want %b", obs, vgreen(S_OH, 8'd19)); else n_pass++;
    step(19);
    n_total++; if (obs !== vgreen(S_OH, 8'd0)) $display("FAIL clr_s_expire: got %b want %b", obs, vgreen(S_OH, 8'd0)); else n_pass++;
    step(1);
    n_total++; if (obs !== vyellow(S_OH, 8'd3)) $display("FAIL clr_s_yellow: got %b want %b", obs, vyellow(S_OH, 8'd3)); else n_pass++;
    step(4);
    n_total++; if (obs !== vallred(8'd1)) $display("FAIL clr_allred: got %b want %b", obs, vallred(8'd1)); else n_pass++;
    step(2);
    n_total++; if (obs !== vgreen(W_OH, 8'd19)) $display("FAIL clr_w_entry: got %b want %b", obs, vgreen(W_OH, 8'd19)); else n_pass++;
    step(19);
    for (int i = 0; i < 10; i++) begin
      step(1);
      n_total++; if (obs !== vgreen(W_OH, 8'd0)) $display("FAIL clr_no_s[%0d]: got %b want %b", i, obs, vgreen(W_OH, 8'd0)); else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    bus.req = S_OH;
    step(1);
    bus.req = 4'b0000;
    n_total++; if (obs !== vyellow(W_OH, 8'd3)) $display("FAIL ar_yellow: got %b want %b", obs, vyellow(W_OH, 8'd3)); else n_pass++;
    step(1);
    n_total++; if (obs !== vyellow(W_OH, 8'd2)) $display("FAIL ar_yellow2: got %b want %b", obs, vyellow(W_OH, 8'd2)); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (obs !== IDLE_V) $display("FAIL ar_immediate: got %b want %b", obs, IDLE_V); else n_pass++;
    step(3);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      n_total++; if (obs !== IDLE_V) $display("FAIL ar_stay_idle[%0d]: got %b want %b", i, obs, IDLE_V); else n_pass++;
    end
  endtask

`ifdef PHASE_PREEMPT_EN
  task automatic test_preempt();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.req = N_OH;
    step(1);
    bus.req = 4'b0000;
    step(4);
    n_total++; if (obs !== vgreen(N_OH, 8'd15)) $display("FAIL pe_n15: got %b want %b", obs, vgreen(N_OH, 8'd15)); else n_pass++;
    bus.preempt     = 1'b1;
    bus.preempt_dir = 2'(DIR_W);
    step(1);
    n_total++; if (obs !== vyellow(N_OH, 8'd3)) $display("FAIL pe_yellow: got %b want %b", obs, vyellow(N_OH, 8'd3)); else n_pass++;
    step(4);
    n_total++; if (obs !== vallred(8'd1)) $display("FAIL pe_allred: got %b want %b", obs, vallred(8'd1)); else n_pass++;
    step(2);
    for (int i = 0; i < 6; i++) begin
      n_total++; if (obs !== vgreen(W_OH, 8'd19)) $display("FAIL pe_w_hold[%0d]: got %b want %b", i, obs, vgreen(W_OH, 8'd19)); else n_pass++;
      step(1);
    end
    // Pointer still at S after the override, so E beats N next.
    bus.preempt = 1'b0;
    bus.req     = N_OH | E_OH;
    step(19);
    step(1);
    n_total++; if (obs !== vyellow(W_OH, 8'd3)) $display("FAIL pe_w_yellow: got %b want %b", obs, vyellow(W_OH, 8'd3)); else n_pass++;
    step(6);
    n_total++; if (obs !== vgreen(E_OH, 8'd19)) $display("FAIL pe_ptr_kept: got %b want %b", obs, vgreen(E_OH, 8'd19)); else n_pass++;
    bus.req = 4'b0000;
  endtask
`endif

  initial begin
`ifdef PHASE_PREEMPT_EN
    bus.preempt     = 1'b0;
    bus.preempt_dir = 2'd0;
`endif
    test_reset();
    test_single_demand();
    test_round_robin();
    test_same_clk_clear();
    test_async_reset();
`ifdef PHASE_PREEMPT_EN
    test_preempt();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/phase_scheduler.md
Name: phase_scheduler

Overview:
- Sequences green, yellow and all-red phases for the N/S/E/W approaches of the intersection.
- Arbitrates vehicle/pedestrian requests from the four approaches round-robin.
- Sits between the tick source (clock divider, used as an enable) and the lamp drivers.
- Replaces fixed-cycle sequencing with demand-driven service.

Parameters:
- CNT_W, 8, width of the phase down-counter.
- GREEN_TICKS, 20, green duration in ticks; 1..2^CNT_W-1.
- YELLOW_TICKS, 4, yellow duration in ticks; 1..2^CNT_W-1.
- ALLRED_TICKS, 2, all-red clearance duration in ticks; 1..2^CNT_W-1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- tick  in  1  one-clk-wide timing enable; all phase timing counts ticks only.
- req  in  4  level requests, bit0=N, bit1=S, bit2=E, bit3=W.
- lamp_green  out  4  per-direction green (same bit order as req).
- lamp_yellow  out  4  per-direction yellow.
- lamp_red  out  4  per-direction red.
- grant  out  4  one-hot direction currently owning GREEN/YELLOW; 0 otherwise.
- remaining  out  CNT_W  ticks left in the current timed phase, minus 1.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (async assert, sync-to-clk release):
  - state=IDLE, pending=0, rr pointer=N, counter=0.
  - lamp_red=4'b1111, lamp_green=0, lamp_yellow=0, grant=0, remaining=0, busy=0.
- All outputs are registered. Lamps for each direction are exactly one-hot among green/yellow/red. At most one direction is non-red at any time.
- Pending latch:
  - Every clk: pending |= req.
  - The bit of the direction being granted is cleared in the cycle GREEN is entered. Clear wins over a simultaneous set for that bit only.
- Arbitration:
  - eligible = pending | req.
  - Round-robin winner is the first eligible bit searching upward from the pointer, wrapping W->N.
  - On grant, pointer = winner+1 (mod 4).
- FSM states: IDLE, GREEN, YELLOW, ALLRED.
- IDLE: all red.
  - If eligible != 0 at any clk (tick not required), go to GREEN for the winner next clk and load counter=GREEN_TICKS-1.
- GREEN: the granted direction is green.
  - On tick with counter!=0: decrement.
  - On tick with counter==0:
    - If any other direction is eligible, go to YELLOW and load YELLOW_TICKS-1.
    - Otherwise rest on green: counter stays 0, re-evaluated each tick.
  - The green therefore lasts exactly GREEN_TICKS ticks minimum.
- YELLOW: same direction yellow; grant is unchanged.
  - On tick with counter==0, go to ALLRED and load ALLRED_TICKS-1.
- ALLRED: all red, grant=0.
  - On tick with counter==0:
    - If eligible != 0, go to GREEN for the winner (same-direction re-grant allowed).
    - Otherwise go to IDLE.
- remaining mirrors the counter; it is 0 in IDLE.
- Ticks arriving in IDLE are ignored. A tick on the same clk as an IDLE->GREEN decision is not counted.
- Simultaneous requests in the same clk are ordered by the pointer only.
- Reset mid-phase aborts immediately to the reset values; any pending requests are lost.

Optional Feature:
- Macro: PHASE_PREEMPT_EN.
- Defined: adds inputs preempt (1) and preempt_dir (2). While preempt=1:
  - A GREEN for a direction other than preempt_dir goes to YELLOW on the next tick, ignoring the remaining count.
  - YELLOW and ALLRED then run normally.
  - ALLRED exits to GREEN for preempt_dir, overriding arbitration.
  - A GREEN already on preempt_dir is held: counter frozen, no YELLOW.
  - The rr pointer is not updated by preempt grants.
  - On preempt deassert, normal GREEN expiry rules resume from the frozen count.
- Undefined: the ports are absent and behaviour is exactly as specified above.

Decomposition:
- Package phase_pkg holds:
  - the state enum (IDLE, GREEN, YELLOW, ALLRED);
  - direction index constants DIR_N=0, DIR_S=1, DIR_E=2, DIR_W=3;
  - a function converting state+grant to a {green,yellow,red} lamp triple.
- Sub-module rr_arbiter4: combinational 4-way round-robin pick from eligible and pointer, returning one-hot winner and valid. The pointer register stays in phase_scheduler.

Test Plan:
1. Reset with req=0 and 50 ticks -> lamp_red=4'b1111, busy=0, grant=0 throughout.
2. Pulse req[2] for one clk, tick every clk -> E green for 20 ticks (rest on green, no other requests); then assert req[0] -> E yellow for exactly 4 ticks, all red for 2 ticks, N green. Pending E is cleared.
3. req=4'b1111 held from reset -> greens in order N,S,E,W,N. Each green lasts 20 ticks, yellow 4, all-red 2. Never two non-red directions.
4. req[1] pulsed on the same clk GREEN(S) is entered -> pending S is cleared and S is not re-served. req[3] pulsed the same clk -> W is latched and served next.
5. Assert rst_n=0 mid-YELLOW without a clk edge -> outputs take reset values immediately. After release with req=0 -> remains IDLE.
6. (PHASE_PREEMPT_EN) N green with 15 ticks left, preempt=1, preempt_dir=W -> next tick N yellow for 4 ticks, all red for 2 ticks, W green held while preempt=1. Rr pointer unchanged.
